// File: rtl/aes_round_engine_if.sv
// aes_round_engine_if: block-in and block-out valid/ready handshakes of the AES round engine
interface aes_round_engine_if;
  logic         inValid, inReady, inMode, outValid, outReady, outMode;
  logic [127:0] inData, outData;
  modport master (output inValid, inMode, inData, outReady, input inReady, outValid, outData, outMode);
  modport slave  (input inValid, inMode, inData, outReady, output inReady, outValid, outData, outMode);
endinterface

// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES encrypt/decrypt core, one full round per clock, host-loaded round keys
module aes_round_engine #(
  parameter int KEY_BITS  = 128,
  parameter int KEY_IDX_W = 4
) (
  input  logic                 clock,
  input  logic                 resetModule_n,
  input  logic                 keyWrite,
  input  logic [KEY_IDX_W-1:0] keyIndex,
  input  logic [127:0]         keyData,
  input  logic                 keyClear,
  output logic                 keysValid,
  output logic                 keyWriteErr,
  output logic                 busy,
  aes_round_engine_if.slave    io
);
  localparam int NR = KEY_BITS == 128 ? 10 : KEY_BITS == 192 ? 12 : KEY_BITS == 256 ? 14 : 0;
  localparam logic [KEY_IDX_W-1:0] NRI = KEY_IDX_W'(NR);
  if (NR == 0) begin : g_bad_key
    $error("KEY_BITS must be 128, 192 or 256");
  end
  if (NR >= (1 << KEY_IDX_W)) begin : g_bad_idx
    $error("KEY_IDX_W cannot hold NR");
  end
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xt(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction
  // S-box as GF(2^8) inverse (x^254) wrapped in the affine map or its inverse
  function automatic logic [7:0] sbox(input logic [7:0] a, input logic inv);
    logic [7:0] b, p, r;
    b = inv ? rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05 : a;
    p = b;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return inv ? r : r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
  endfunction
  function automatic logic [127:0] sub_bytes(input logic [127:0] x, input logic inv);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[127-8*i -: 8] = sbox(x[127-8*i -: 8], inv);
    return y;
  endfunction
  function automatic logic [127:0] shift_rows(input logic [127:0] x, input logic inv);
    logic [127:0] y;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[127-8*(r+4*c) -: 8] = x[127-8*(r+4*((inv ? c - r + 4 : c + r) % 4)) -: 8];
    return y;
  endfunction
  function automatic logic [7:0] coef(input int k, input logic inv);
    return inv ? (k == 0 ? 8'd14 : k == 1 ? 8'd11 : k == 2 ? 8'd13 : 8'd9) : (k == 0 ? 8'd2 : k == 1 ? 8'd3 : 8'd1);
  endfunction
  function automatic logic [127:0] mix_columns(input logic [127:0] x, input logic inv);
    logic [127:0] y;
    logic [7:0]   acc;
    y = '0;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) begin
        acc = '0;
        for (int j = 0; j < 4; j++) acc ^= gmul(coef((j - i + 4) % 4, inv), x[127-8*(4*c+j) -: 8]);
        y[127-8*(4*c+i) -: 8] = acc;
      end
    return y;
  endfunction
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  state_t               state, nxt;
  logic [127:0]         rk [0:NR];
  logic [NR:0]          mask;
  logic [127:0]         st, rk_sel, fwd_sr, fwd, inv_ark, bwd;
  logic [KEY_IDX_W-1:0] r;
  logic                 mode, last, accept, key_ok;
  assign key_ok      = keyWrite && state == IDLE && keyIndex <= NRI;
  assign keysValid   = &mask;
  assign io.inReady  = state == IDLE && keysValid && !keyWrite && !keyClear;
  assign io.outValid = state == DONE;
  assign busy        = state == ROUND;
  assign accept      = io.inValid && io.inReady;
  assign last        = r == NRI;
  // decrypt walks the key schedule backwards, so both directions share one index mux
  assign rk_sel  = rk[mode ? NRI - r : r];
  assign fwd_sr  = shift_rows(sub_bytes(st, 1'b0), 1'b0);
  assign fwd     = (last ? fwd_sr : mix_columns(fwd_sr, 1'b0)) ^ rk_sel;
  assign inv_ark = sub_bytes(shift_rows(st, 1'b1), 1'b1) ^ rk_sel;
  assign bwd     = last ? inv_ark : mix_columns(inv_ark, 1'b1);
  always_comb begin
    nxt = IDLE;
    if (state == IDLE) nxt = accept ? ROUND : IDLE;
    else if (state == ROUND) nxt = last ? DONE : ROUND;
    else if (state == DONE) nxt = io.outReady ? IDLE : DONE;
  end
  always_ff @(posedge clock or negedge resetModule_n)
    if (!resetModule_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clock)
    if (key_ok) rk[keyIndex] <= keyData;
  always_ff @(posedge clock or negedge resetModule_n)
    if (!resetModule_n) begin
      mask        <= '0;
      keyWriteErr <= 1'b0;
      st          <= '0;
      r           <= '0;
      mode        <= 1'b0;
      io.outData  <= '0;
      io.outMode  <= 1'b0;
    end else begin
      mask        <= keyClear ? '0 : key_ok ? mask | ((NR+1)'(1) << keyIndex) : mask;
      keyWriteErr <= keyWrite && !key_ok;
      if (accept) begin
        mode <= io.inMode;
        st   <= io.inData ^ (io.inMode ? rk[NR] : rk[0]);
        r    <= KEY_IDX_W'(1);
      end else if (state == ROUND) begin
        st <= mode ? bwd : fwd;
        r  <= last ? r : r + 1'b1;
        if (last) begin
          io.outData <= mode ? bwd : fwd;
          io.outMode <= mode;
        end
      end
    end
endmodule

// File: tb/tb_aes_round_engine.sv
// tb_aes_round_engine: randomized scoreboard bench for aes_round_engine against a table-driven AES model
module tb_aes_round_engine;
  localparam int KEY_BITS  = 128;
  localparam int KEY_IDX_W = 4;
  localparam int NR = KEY_BITS == 128 ? 10 : KEY_BITS == 192 ? 12 : 14;
  localparam int NK = KEY_BITS / 32;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT = KEY_BITS == 192 ? 128'hdda97ca4864cdfe06eaf70a0ec0d7191 :
                                 KEY_BITS == 256 ? 128'h8ea2b7ca516745bfeafc49904b496089 :
                                                   128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic                 clock = 0, resetModule_n = 0;
  logic                 keyWrite = 0, keyClear = 0, keysValid, keyWriteErr, busy;
  logic [KEY_IDX_W-1:0] keyIndex = '0;
  logic [127:0]         keyData = '0;
  aes_round_engine_if io();
  aes_round_engine #(.KEY_BITS(KEY_BITS), .KEY_IDX_W(KEY_IDX_W)) dut (
    .clock(clock), .resetModule_n(resetModule_n), .keyWrite(keyWrite), .keyIndex(keyIndex),
    .keyData(keyData), .keyClear(keyClear), .keysValid(keysValid), .keyWriteErr(keyWriteErr),
    .busy(busy), .io(io));
  always #5 clock = ~clock;
  typedef struct { logic [127:0] d; logic m; int acc; } exp_t;
  exp_t         sb[$];
  int           errors = 0, checks = 0, cyc = 0;
  bit           rnd_ready = 0;
  logic [7:0]   sbt [256], isbt [256];
  logic [127:0] mrk [0:14];
  always @(posedge clock) cyc++;
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", nm);
  endtask
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] rl(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction
  // S-box built by walking the multiplicative group with generator 3 and its inverse
  function automatic void build_tables();
    logic [7:0] p = 8'h01, q = 8'h01, x;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q ^= q << 1;
      q ^= q << 2;
      q ^= q << 4;
      if (q[7]) q ^= 8'h09;
      x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
      sbt[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbt[0] = 8'h63;
    for (int i = 0; i < 256; i++) isbt[sbt[i]] = 8'(i);
  endfunction
  function automatic logic [127:0] m_sub(input logic [127:0] x, input bit inv);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[127-8*i -: 8] = inv ? isbt[x[127-8*i -: 8]] : sbt[x[127-8*i -: 8]];
    return y;
  endfunction
  function automatic logic [127:0] m_shift(input logic [127:0] x, input bit inv);
    logic [127:0] y;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        int s = r + 4 * ((c + r) % 4);
        int d = r + 4 * c;
        if (inv) y[127-8*s -: 8] = x[127-8*d -: 8];
        else y[127-8*d -: 8] = x[127-8*s -: 8];
      end
    return y;
  endfunction
  function automatic logic [127:0] m_mix(input logic [127:0] x, input bit inv);
    logic [127:0] y;
    logic [7:0]   a0, a1, a2, a3, u, v, t;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = x[127-32*c -: 32];
      if (inv) begin
        u = xt(xt(a0 ^ a2));
        v = xt(xt(a1 ^ a3));
        a0 ^= u; a1 ^= v; a2 ^= u; a3 ^= v;
      end
      t = a0 ^ a1 ^ a2 ^ a3;
      y[127-32*c -: 32] = {a0 ^ t ^ xt(a0 ^ a1), a1 ^ t ^ xt(a1 ^ a2), a2 ^ t ^ xt(a2 ^ a3), a3 ^ t ^ xt(a3 ^ a0)};
    end
    return y;
  endfunction
  function automatic logic [127:0] model(input logic [127:0] x, input bit dec);
    logic [127:0] s;
    if (!dec) begin
      s = x ^ mrk[0];
      for (int i = 1; i <= NR; i++) begin
        s = m_shift(m_sub(s, 0), 0);
        if (i < NR) s = m_mix(s, 0);
        s ^= mrk[i];
      end
    end else begin
      s = x ^ mrk[NR];
      for (int i = NR - 1; i >= 0; i--) begin
        s = m_sub(m_shift(s, 1), 1) ^ mrk[i];
        if (i > 0) s = m_mix(s, 1);
      end
    end
    return s;
  endfunction
  function automatic void expand(input logic [255:0] key);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4 * (NR + 1); i++) begin
      if (i < NK) w[i] = key[255-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % NK == 0) begin
          t = {sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]], sbt[t[31:24]]} ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (NK > 6 && i % NK == 4) t = {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]};
        w[i] = w[i-NK] ^ t;
      end
    end
    for (int r = 0; r <= NR; r++) mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction
  task automatic tick();
    @(posedge clock);
    #1;
    if (rnd_ready) io.outReady = 1'($urandom_range(0, 1));
  endtask
  task automatic kw(input int idx, input logic [127:0] d);
    keyWrite = 1;
    keyIndex = KEY_IDX_W'(idx);
    keyData  = d;
    tick();
    keyWrite = 0;
  endtask
  task automatic load_keys();
    for (int r = 0; r <= NR; r++) kw(r, mrk[r]);
  endtask
  task automatic send(input logic [127:0] d, input logic m, input logic [127:0] e);
    int n = 0;
    io.inValid = 1;
    io.inData  = d;
    io.inMode  = m;
    @(negedge clock);
    while (!io.inReady && n < 300) begin
      tick();
      @(negedge clock);
      n++;
    end
    if (!io.inReady) timeout("accept");
    else sb.push_back('{e, m, cyc + 1});
    tick();
    io.inValid = 0;
    io.inData  = {$urandom, $urandom, $urandom, $urandom};
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || io.outValid || busy) && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) timeout("drain");
  endtask
  logic         pv = 0, pm = 0;
  logic [127:0] pd = '0;
  always @(negedge clock) begin
    if (io.outValid) begin
      if (!pv) begin
        if (sb.size() == 0) timeout("spurious_outValid");
        else chk("latency", 128'(cyc - sb[0].acc), 128'(NR));
      end else chk("hold_stable", {io.outMode, io.outData}, {pm, pd});
      chk("inReady_in_done", 128'(io.inReady), 128'(0));
      if (io.outReady && sb.size() != 0) begin
        chk("outData", io.outData, sb[0].d);
        chk("outMode", 128'(io.outMode), 128'(sb[0].m));
        void'(sb.pop_front());
      end
    end
    pv = io.outValid;
    pd = io.outData;
    pm = io.outMode;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [255:0] key;
    logic [127:0] d;
    io.inValid = 0; io.inMode = 0; io.inData = '0; io.outReady = 1;
    build_tables();
    for (int i = 0; i < 32; i++) key[255-8*i -: 8] = 8'(i);
    expand(key);
    #12;
    chk("rst_outValid", 128'(io.outValid), 0);
    chk("rst_outData", io.outData, 0);
    chk("rst_outMode", 128'(io.outMode), 0);
    chk("rst_busy", 128'(busy), 0);
    chk("rst_keysValid", 128'(keysValid), 0);
    chk("rst_inReady", 128'(io.inReady), 0);
    chk("rst_keyWriteErr", 128'(keyWriteErr), 0);
    #1 resetModule_n = 1;
    tick();
    for (int r = 0; r < NR; r++) kw(r, mrk[r]);
    io.inValid = 1;
    chk("partial_keysValid", 128'(keysValid), 0);
    chk("partial_inReady", 128'(io.inReady), 0);
    io.inValid = 0;
    kw(NR, mrk[NR]);
    chk("full_keysValid", 128'(keysValid), 1);
    chk("good_write_err", 128'(keyWriteErr), 0);
    kw(15, '1);
    chk("bad_index_err", 128'(keyWriteErr), 1);
    tick();
    chk("err_one_pulse", 128'(keyWriteErr), 0);
    chk("bad_index_keep", 128'(keysValid), 1);
    keyClear = 1;
    tick();
    keyClear = 0;
    chk("clear_keysValid", 128'(keysValid), 0);
    load_keys();
    send(PT, 0, KAT);
    wait_idle();
    send(KAT, 1, PT);
    wait_idle();
    send(PT, 0, KAT);
    tick();
    tick();
    kw(1, '1);
    chk("round_write_err", 128'(keyWriteErr), 1);
    chk("round_busy", 128'(busy), 1);
    wait_idle();
    send(KAT, 1, PT);
    wait_idle();
    io.outReady = 0;
    send(PT, 0, KAT);
    for (int n = 0; n < 100 && !io.outValid; n++) tick();
    if (!io.outValid) timeout("bp_outValid");
    repeat (20) tick();
    chk("bp_held", 128'(io.outValid), 1);
    io.outReady = 1;
    tick();
    chk("release_inReady", 128'(io.inReady), 1);
    send(KAT, 1, PT);
    chk("next_accepted", 128'(busy), 1);
    wait_idle();
    send(KAT, 1, PT);
    repeat (4) tick();
    chk("pre_reset_busy", 128'(busy), 1);
    #2 resetModule_n = 0;
    #1;
    chk("ar_outValid", 128'(io.outValid), 0);
    chk("ar_outData", io.outData, 0);
    chk("ar_outMode", 128'(io.outMode), 0);
    chk("ar_busy", 128'(busy), 0);
    chk("ar_keysValid", 128'(keysValid), 0);
    chk("ar_inReady", 128'(io.inReady), 0);
    sb.delete();
    repeat (2) @(posedge clock);
    #3 resetModule_n = 1;
    tick();
    io.inValid = 1;
    repeat (30) tick();
    chk("post_reset_outValid", 128'(io.outValid), 0);
    chk("post_reset_busy", 128'(busy), 0);
    io.inValid = 0;
    load_keys();
    rnd_ready = 1;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      d = {$urandom, $urandom, $urandom, $urandom};
      send(d, 1'(i), model(d, 1'(i)));
    end
    wait_idle();
    rnd_ready = 0;
    io.outReady = 1;
    chk("sb_empty", 128'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
